mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Memory-access stage of the 32-bit MIPS pipeline. Consumes the EX/MEM pipeline register outputs, performs data-memory loads and stores over a request/acknowledge bus, and drives the MEM/WB pipeline register. While a memory access is outstanding it stalls upstream stages and inserts bubbles into write-back. It also bounds each access with a timeout.

## Interface
- n, 32, datapath width.
- MAX_WAIT, 15, maximum BUSY cycles without ack before an access is abandoned (1..255).

- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous and active-low.
- RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in  in  1 each  control bits from EX/MEM.
- ALU_Result_in  in  n  effective address, or result for non-memory instructions.
- RT_data_in  in  n  store data.
- Write_reg_in  in  5  destination register number.
- dmem_req  out  1  memory request; registered.
- dmem_we  out  1  1 = store, 0 = load; registered.
- dmem_addr  out  n  registered copy of ALU_Result_in.
- dmem_wdata  out  n  registered copy of RT_data_in.
- dmem_rdata  in  n  load data; valid when dmem_ack = 1.
- dmem_ack  in  1  access complete; sampled only in BUSY.
- mem_stall  out  1  combinational; upstream stages hold while 1.
- bus_err  out  1  one-cycle pulse when an access times out.
- RegWrite_out, MemtoReg_out  out  1 each  MEM/WB control.
- Read_data_out, ALU_Result_out  out  n  MEM/WB data.
- Write_reg_out  out  5  MEM/WB destination.

## Operation
- The FSM has two states: IDLE and BUSY. It also has a wait counter, width ceil(log2(MAX_WAIT+1)).
- mem_op = MemRead_in | MemWrite_in. If both bits are 1, the instruction is a load: no write is issued and dmem_we = 0.
- **IDLE, mem_op = 0:**
  - At the edge, MEM/WB loads RegWrite_in, MemtoReg_in, ALU_Result_in and Write_reg_in.
  - Read_data_out holds its previous value.
- **IDLE, mem_op = 1:**
  - At the edge, dmem_req, dmem_we, dmem_addr and dmem_wdata are registered, and the FSM moves to BUSY.
  - The MEM/WB register loads a bubble: RegWrite_out = 0, MemtoReg_out = 0, other MEM/WB fields unchanged.
  - The wait counter clears.
- **BUSY, dmem_ack = 1:**
  - At the edge, dmem_req goes to 0 and the FSM returns to IDLE.
  - MEM/WB loads the held instruction's RegWrite_in, MemtoReg_in, ALU_Result_in and Write_reg_in.
  - For a load, Read_data_out loads dmem_rdata. For a store, Read_data_out is unchanged.
- **BUSY, dmem_ack = 0:**
  - The counter increments and the MEM/WB register loads a bubble.
  - If the counter equals MAX_WAIT-1 at this edge, the access is abandoned: dmem_req goes to 0, the FSM returns to IDLE, bus_err pulses 1 for the following cycle, and MEM/WB loads a bubble.
- mem_stall = (IDLE & mem_op) | (BUSY & ~dmem_ack & ~timeout_hit), where timeout_hit = (counter == MAX_WAIT-1).
- In the completing cycle mem_stall = 0, so the upstream register advances on the same edge that MEM/WB captures the result.
- Upstream keeps all *_in signals stable while mem_stall = 1. The block does not re-sample them in BUSY and uses only its registered copies for the bus.
- An ack received while in IDLE is ignored.
- Address alignment is not checked. dmem_addr is passed through unmodified.

## Timing
- Reset (rst_n = 0, takes effect immediately): FSM = IDLE, counter = 0.
  - All outputs are 0: dmem_req, dmem_we, dmem_addr, dmem_wdata, bus_err, and every MEM/WB output.
  - mem_stall follows its equation, so it can be 1 during reset if mem_op = 1.
- A reset asserted mid-access drops dmem_req asynchronously. No bus_err is raised and the access is lost.
- Non-memory instruction: MEM/WB outputs are valid 1 cycle after the instruction is presented.
- Memory access, with the op presented in cycle 0:
  - dmem_req = 1 from cycle 1.
  - If dmem_ack arrives in cycle k ≥ 1, MEM/WB outputs are valid in cycle k+1.
  - Minimum latency is 2 cycles.
- dmem_req stays high continuously from issue until ack or timeout. Address, data and we are stable throughout.
- Back-to-back memory ops: the next op is registered at the edge following completion. There is one IDLE cycle between requests, and dmem_req goes low for 1 cycle.
- Timeout: with no ack, dmem_req is high for exactly MAX_WAIT cycles, and bus_err is high in the cycle after the last of them.

## Test plan
- **Reset:** assert rst_n = 0 mid-simulation with dmem_req = 1 → dmem_req drops immediately, all MEM/WB outputs = 0, and after release the FSM is in IDLE.
- **ALU pass-through:** present RegWrite_in = 1, ALU_Result_in = 32'h9, Write_reg_in = 5'd8 → the next cycle shows RegWrite_out = 1, ALU_Result_out = 32'h9, Write_reg_out = 8, and mem_stall stays 0 throughout.
- **Load, ack after 3 cycles:** present MemRead_in = 1, MemtoReg_in = 1, address 32'h10, with dmem_rdata = 32'hDEADBEEF →
  - mem_stall is 1 for cycles 0..2;
  - dmem_req is 1 for cycles 1..3 with dmem_addr = 32'h10 and dmem_we = 0;
  - RegWrite_out = 0 during the wait;
  - in cycle 4, Read_data_out = 32'hDEADBEEF and RegWrite_out = 1.
- **Store, ack in first BUSY cycle:** present MemWrite_in = 1, RT_data_in = 32'h3, address 32'h20 → dmem_we = 1 and dmem_wdata = 32'h3 in cycle 1; Read_data_out is unchanged; total latency 2 cycles.
- **Timeout, MAX_WAIT = 4, ack never asserted:** dmem_req is high for exactly 4 cycles, bus_err pulses 1 for one cycle, MEM/WB holds a bubble, mem_stall falls, and the next instruction proceeds.
- **Both MemRead_in and MemWrite_in = 1, plus a spurious ack in IDLE:** the op is issued as a load (dmem_we = 0), and the IDLE ack causes no state change.

Source files
------------

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: issues data-memory loads/stores over a req/ack bus, stalls
// upstream while an access is outstanding, and abandons accesses after MAX_WAIT cycles.
module mem_access_stage #(
  parameter int n        = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         RegWrite_in,
  input  logic         MemtoReg_in,
  input  logic         MemRead_in,
  input  logic         MemWrite_in,
  input  logic [n-1:0] ALU_Result_in,
  input  logic [n-1:0] RT_data_in,
  input  logic [4:0]   Write_reg_in,
  output logic         dmem_req,
  output logic         dmem_we,
  output logic [n-1:0] dmem_addr,
  output logic [n-1:0] dmem_wdata,
  input  logic [n-1:0] dmem_rdata,
  input  logic         dmem_ack,
  output logic         mem_stall,
  output logic         bus_err,
  output logic         RegWrite_out,
  output logic         MemtoReg_out,
  output logic [n-1:0] Read_data_out,
  output logic [n-1:0] ALU_Result_out,
  output logic [4:0]   Write_reg_out
);
  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          h_rw, h_mtr, h_load;
  logic [4:0]    h_wr;
  logic          mem_op, timeout_hit;

  assign mem_op      = MemRead_in | MemWrite_in;
  assign timeout_hit = (cnt == CW'(MAX_WAIT - 1));
  assign mem_stall   = ((state == IDLE) & mem_op) |
                       ((state == BUSY) & ~dmem_ack & ~timeout_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      h_rw           <= 1'b0;
      h_mtr          <= 1'b0;
      h_load         <= 1'b0;
      h_wr           <= '0;
      dmem_req       <= 1'b0;
      dmem_we        <= 1'b0;
      dmem_addr      <= '0;
      dmem_wdata     <= '0;
      bus_err        <= 1'b0;
      RegWrite_out   <= 1'b0;
      MemtoReg_out   <= 1'b0;
      Read_data_out  <= '0;
      ALU_Result_out <= '0;
      Write_reg_out  <= '0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_op) begin
            // Read wins when both bits are set: never issue a write by accident.
            dmem_req     <= 1'b1;
            dmem_we      <= MemWrite_in & ~MemRead_in;
            dmem_addr    <= ALU_Result_in;
            dmem_wdata   <= RT_data_in;
            h_rw         <= RegWrite_in;
            h_mtr        <= MemtoReg_in;
            h_wr         <= Write_reg_in;
            h_load       <= MemRead_in;
            cnt          <= '0;
            state        <= BUSY;
            RegWrite_out <= 1'b0;
            MemtoReg_out <= 1'b0;
          end else begin
            RegWrite_out   <= RegWrite_in;
            MemtoReg_out   <= MemtoReg_in;
            ALU_Result_out <= ALU_Result_in;
            Write_reg_out  <= Write_reg_in;
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            dmem_req       <= 1'b0;
            state          <= IDLE;
            RegWrite_out   <= h_rw;
            MemtoReg_out   <= h_mtr;
            ALU_Result_out <= dmem_addr;
            Write_reg_out  <= h_wr;
            if (h_load) Read_data_out <= dmem_rdata;
          end else begin
            RegWrite_out <= 1'b0;
            MemtoReg_out <= 1'b0;
            if (timeout_hit) begin
              dmem_req <= 1'b0;
              state    <= IDLE;
              bus_err  <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: a driver pushes expected MEM/WB results,
// a monitor pops and compares whenever an instruction leaves the stage.
module tb_mem_access_stage;
  localparam int MW = 4;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        RegWrite_in = 0, MemtoReg_in = 0, MemRead_in = 0, MemWrite_in = 0;
  logic [31:0] ALU_Result_in = '0, RT_data_in = '0, dmem_rdata = '0;
  logic [4:0]  Write_reg_in = '0;
  logic        dmem_ack = 1'b0;
  logic        dmem_req, dmem_we, mem_stall, bus_err, RegWrite_out, MemtoReg_out;
  logic [31:0] dmem_addr, dmem_wdata, Read_data_out, ALU_Result_out;
  logic [4:0]  Write_reg_out;

  mem_access_stage #(.n(32), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in),
    .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .ALU_Result_in(ALU_Result_in), .RT_data_in(RT_data_in), .Write_reg_in(Write_reg_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .mem_stall(mem_stall), .bus_err(bus_err),
    .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out),
    .Read_data_out(Read_data_out), .ALU_Result_out(ALU_Result_out), .Write_reg_out(Write_reg_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw, mtr, err;
    logic [31:0] alu, rd;
    logic [4:0]  wr;
  } exp_t;

  exp_t        q[$];
  int          checks = 0, errors = 0;
  logic        inst_vld = 1'b0;
  logic        pend = 1'b0;
  logic [31:0] m_alu = '0, m_rd = '0;
  logic [4:0]  m_wr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: an instruction leaves the stage on an edge where it is presented and not stalled.
  always @(negedge clk) begin
    if (pend) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL mon_queue: result seen with empty expected queue at %0t", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("mon_RegWrite", 32'(RegWrite_out), 32'(e.rw));
        chk("mon_MemtoReg", 32'(MemtoReg_out), 32'(e.mtr));
        chk("mon_ALU_Result", ALU_Result_out, e.alu);
        chk("mon_Write_reg", 32'(Write_reg_out), 32'(e.wr));
        chk("mon_Read_data", Read_data_out, e.rd);
        chk("mon_bus_err", 32'(bus_err), 32'(e.err));
      end
    end
    pend = inst_vld && !mem_stall;
  end

  task automatic nop_inputs();
    RegWrite_in = 0; MemtoReg_in = 0; MemRead_in = 0; MemWrite_in = 0;
    ALU_Result_in = '0; RT_data_in = '0; Write_reg_in = '0; dmem_ack = 0;
    inst_vld = 0;
  endtask

  // Idle cycles load the all-zero nop into MEM/WB.
  task automatic idle(input int cycles);
    nop_inputs();
    repeat (cycles) begin @(posedge clk); #1; end
    m_alu = '0; m_wr = '0;
  endtask

  // Called at posedge+1; ack_cyc < 0 means never ack.
  task automatic run_op(input string name, input logic rw, mtr, mr, mw,
                        input logic [31:0] alu, rt, input logic [4:0] wr,
                        input logic [31:0] rdata, input int ack_cyc, input logic spur,
                        input int exp_lat, input int exp_req);
    exp_t e;
    int   cyc, req_cnt;
    logic mem, done;
    mem = mr | mw;
    RegWrite_in = rw; MemtoReg_in = mtr; MemRead_in = mr; MemWrite_in = mw;
    ALU_Result_in = alu; RT_data_in = rt; Write_reg_in = wr; dmem_rdata = rdata;
    if (mem && ack_cyc < 0) begin
      e.rw = 0; e.mtr = 0; e.alu = m_alu; e.wr = m_wr; e.rd = m_rd; e.err = 1;
    end else begin
      e.rw = rw; e.mtr = mtr; e.alu = alu; e.wr = wr; e.err = 0;
      if (mr) m_rd = rdata;
      e.rd = m_rd;
      m_alu = alu; m_wr = wr;
    end
    q.push_back(e);
    inst_vld = 1;
    req_cnt = 0;
    done = 0;
    for (cyc = 0; cyc < 40; cyc++) begin
      dmem_ack = (cyc == ack_cyc) || (spur && cyc == 0);
      @(negedge clk);
      if (dmem_req) req_cnt++;
      if (mem && cyc == 1) begin
        chk({name, "_req"}, 32'(dmem_req), 32'd1);
        chk({name, "_addr"}, dmem_addr, alu);
        chk({name, "_we"}, 32'(dmem_we), 32'(mw & ~mr));
        chk({name, "_wdata"}, dmem_wdata, rt);
      end
      if (mem && cyc >= 1) chk({name, "_bubble"}, 32'(RegWrite_out), 32'd0);
      if (!mem) chk({name, "_nostall"}, 32'(mem_stall), 32'd0);
      done = !mem_stall;
      @(posedge clk); #1;
      if (done) break;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s_timeout: stage never released after 40 cycles", name);
    end
    chk({name, "_latency"}, 32'(cyc + 1), 32'(exp_lat));
    chk({name, "_req_cycles"}, 32'(req_cnt), 32'(exp_req));
    nop_inputs();
  endtask

  initial begin
    nop_inputs();
    #2;
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_RegWrite", 32'(RegWrite_out), 32'd0);
    chk("rst_ALU", ALU_Result_out, 32'd0);
    chk("rst_Read_data", Read_data_out, 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("alu", 1, 0, 0, 0, 32'h9, 32'h0, 5'd8, 32'h0, -1, 0, 1, 0);
    run_op("load", 1, 1, 1, 0, 32'h10, 32'h0, 5'd9, 32'hDEADBEEF, 3, 0, 4, 3);
    run_op("store", 0, 0, 0, 1, 32'h20, 32'h3, 5'd0, 32'h12345678, 1, 0, 2, 1);
    idle(1);
    run_op("tmo", 1, 1, 1, 0, 32'h40, 32'h0, 5'd5, 32'h55555555, -1, 0, MW + 1, MW);
    run_op("alu2", 1, 0, 0, 0, 32'h77, 32'h0, 5'd3, 32'h0, -1, 0, 1, 0);
    run_op("both", 1, 1, 1, 1, 32'h30, 32'hAA, 5'd7, 32'hCAFEF00D, 2, 1, 3, 2);

    // Reset while a load is outstanding: request must drop immediately.
    RegWrite_in = 1; MemtoReg_in = 1; MemRead_in = 1; ALU_Result_in = 32'h50; Write_reg_in = 5'd4;
    @(posedge clk); #1;
    chk("rstmid_req_before", 32'(dmem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_req", 32'(dmem_req), 32'd0);
    chk("rstmid_RegWrite", 32'(RegWrite_out), 32'd0);
    chk("rstmid_ALU", ALU_Result_out, 32'd0);
    chk("rstmid_Read_data", Read_data_out, 32'd0);
    chk("rstmid_Write_reg", 32'(Write_reg_out), 32'd0);
    nop_inputs();
    m_alu = '0; m_wr = '0; m_rd = '0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_no_err", 32'(bus_err), 32'd0);
    run_op("alu3", 1, 0, 0, 0, 32'h123, 32'h0, 5'd31, 32'h0, -1, 0, 1, 0);
    idle(2);

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
